// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: writeback source, MDU valid/ready source,
// the merged write port and the hazard/stall side outputs.
interface regfile_wr_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic [31:0] pending_mask;
    logic        stall_req;

    modport master (
        output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, regwrite, rd, writedata, pending_mask, stall_req
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, regwrite, rd, writedata, pending_mask, stall_req
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Merges the fixed-priority writeback stream and the buffered MDU result stream
// onto the single register-file write port, with hazard mask and anti-starvation stall.
module regfile_wr_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [4:0]            ent_rd_q   [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [3:0]            age_q, age_d;
    logic                  regwrite_q, regwrite_d;
    logic [4:0]            rd_q, rd_d;
    logic [31:0]           wdata_q, wdata_d;

    logic wb_grant, nonempty, head_live, pop, enq, mdu_grant;
    logic [31:0] mask;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign bus.mdu_ready = (count_q < CW'(FIFO_DEPTH));
    assign enq           = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rd != 5'd0);
    assign wb_grant      = bus.wb_valid && (bus.wb_rd != 5'd0);
    assign nonempty      = (count_q != '0);
    assign head_live     = live_q[rptr_q];
    // The head leaves whenever WB does not claim the port, dead or alive.
    assign pop           = nonempty && !wb_grant;
    assign mdu_grant     = pop && head_live;

    always_comb begin
        live_d     = live_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        age_d      = age_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;

        if (wb_grant) begin
            regwrite_d = 1'b1;
            rd_d       = bus.wb_rd;
            wdata_d    = bus.wb_data;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_rd_q[i] == bus.wb_rd) live_d[i] = 1'b0;
            end
        end else if (mdu_grant) begin
            regwrite_d = 1'b1;
            rd_d       = ent_rd_q[rptr_q];
            wdata_d    = ent_data_q[rptr_q];
        end

        if (pop) begin
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + 1'b1;
        end
        // Applied after the kill so a same-cycle enqueue is never killed.
        if (enq) begin
            live_d[wptr_q] = 1'b1;
            wptr_d         = wptr_q + 1'b1;
        end

        if (enq && !pop)      count_d = count_q + 1'b1;
        else if (!enq && pop) count_d = count_q - 1'b1;

        if (!nonempty || pop)          age_d = 4'd0;
        else if (head_live && wb_grant) age_d = sat_inc4(age_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            age_q      <= 4'd0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wdata_q    <= 32'd0;
        end else begin
            live_q     <= live_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_rd_q[wptr_q]   <= bus.mdu_rd;
            ent_data_q[wptr_q] <= bus.mdu_data;
        end
    end

    always_comb begin
        mask = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_q[i]) mask[ent_rd_q[i]] = 1'b1;
        end
    end

    assign bus.pending_mask = mask;
    assign bus.stall_req    = (age_q >= 4'(STARVE_LIMIT));
    assign bus.regwrite     = regwrite_q;
    assign bus.rd           = rd_q;
    assign bus.writedata    = wdata_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: writes to r16..r31 are tracked in one
// queue and writes to r1..r15 in another, each checked in order as they appear.
module tb_regfile_wr_arbiter;
    logic clk, rst;
    int   total = 0;
    int   bad   = 0;

    logic [36:0] hiq[$];
    logic [36:0] loq[$];

    regfile_wr_arbiter_if bus();

    regfile_wr_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.mdu_valid = 1'b0;
        bus.mdu_rd    = 5'd0;
        bus.mdu_data  = 32'd0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        if (r >= 5'd16) hiq.push_back({r, d});
        else if (r != 5'd0) loq.push_back({r, d});
    endtask

    task automatic mdu(input logic [4:0] r, input logic [31:0] d);
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = r;
        bus.mdu_data  = d;
    endtask

    // Write monitor: every register-file write must match the head of its stream.
    always @(negedge clk) begin
        logic [36:0] e;
        if (!rst && bus.regwrite) begin
            if (bus.rd >= 5'd16) begin
                if (hiq.size() == 0) chk("spurious_hi", {1'b1, bus.rd, bus.writedata}, 64'd0);
                else begin
                    e = hiq.pop_front();
                    chk("wr_hi", {bus.rd, bus.writedata}, e);
                end
            end else begin
                if (loq.size() == 0) chk("spurious_lo", {1'b1, bus.rd, bus.writedata}, 64'd0);
                else begin
                    e = loq.pop_front();
                    chk("wr_lo", {bus.rd, bus.writedata}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        accepted;
        logic        done;
        logic [4:0]  r;
        logic [31:0] d;
        int          guard;
        int          len;

        idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_regwrite", bus.regwrite, 1'b0);
        chk("rst_rd", bus.rd, 5'd0);
        chk("rst_wdata", bus.writedata, 32'd0);
        chk("rst_mask", bus.pending_mask, 32'd0);
        chk("rst_stall", bus.stall_req, 1'b0);
        chk("rst_ready", bus.mdu_ready, 1'b1);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", bus.mdu_ready, 1'b1);

        // WB only
        wb(5'd5, 32'hDEADBEEF);
        tick();
        chk("wb_regwrite", bus.regwrite, 1'b1);
        chk("wb_rd", bus.rd, 5'd5);
        chk("wb_data", bus.writedata, 32'hDEADBEEF);
        wb(5'd0, 32'h12345678);
        tick();
        chk("wb_r0_regwrite", bus.regwrite, 1'b0);
        chk("wb_r0_hold_rd", bus.rd, 5'd5);
        idle();
        tick();

        // MDU fill while WB busy, then drain
        wb(5'd20, 32'h100); mdu(5'd3, 32'h33);
        tick();
        wb(5'd20, 32'h101); mdu(5'd4, 32'h44);
        loq.push_back({5'd3, 32'h33});
        loq.push_back({5'd4, 32'h44});
        tick();
        wb(5'd20, 32'h102); mdu(5'd9, 32'h99);
        chk("fill_ready", bus.mdu_ready, 1'b0);
        chk("fill_mask", bus.pending_mask, 32'h18);
        tick();
        idle();
        tick();
        chk("drain_r3", {bus.regwrite, bus.rd}, {1'b1, 5'd3});
        chk("drain_mask1", bus.pending_mask, 32'h10);
        tick();
        chk("drain_r4", {bus.regwrite, bus.rd}, {1'b1, 5'd4});
        chk("drain_mask0", bus.pending_mask, 32'h0);
        tick();

        // Kill: queued r7 overwritten by younger WB r7
        wb(5'd20, 32'h200); mdu(5'd7, 32'h11);
        tick();
        wb(5'd20, 32'h201); mdu(5'd8, 32'h88);
        tick();
        bus.mdu_valid = 1'b0;
        wb(5'd7, 32'h22);
        chk("kill_mask_before", bus.pending_mask, 32'h180);
        tick();
        chk("kill_mask_after", bus.pending_mask, 32'h100);
        idle();
        loq.push_back({5'd8, 32'h88});
        tick();
        chk("kill_idle_cycle", bus.regwrite, 1'b0);
        tick();
        chk("kill_next_r8", {bus.regwrite, bus.rd}, {1'b1, 5'd8});
        tick();

        // Starvation
        wb(5'd21, 32'h300); mdu(5'd9, 32'h99);
        tick();
        bus.mdu_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("starve_stall_%0d", k), bus.stall_req, (k == 5));
            if (k < 5) begin
                wb(5'd21, 32'h300 + k);
                tick();
            end
        end
        idle();
        loq.push_back({5'd9, 32'h99});
        tick();
        chk("starve_head_written", {bus.regwrite, bus.rd}, {1'b1, 5'd9});
        chk("starve_stall_fall", bus.stall_req, 1'b0);
        tick();

        // Full FIFO refuses an offer even while popping
        wb(5'd20, 32'h400); mdu(5'd1, 32'h1001);
        tick();
        wb(5'd20, 32'h401); mdu(5'd2, 32'h1002);
        loq.push_back({5'd1, 32'h1001});
        loq.push_back({5'd2, 32'h1002});
        tick();
        bus.wb_valid = 1'b0;
        mdu(5'd3, 32'h1003);
        chk("full_ready0", bus.mdu_ready, 1'b0);
        tick();
        chk("full_ready1", bus.mdu_ready, 1'b1);
        loq.push_back({5'd3, 32'h1003});
        tick();
        idle();
        repeat (3) tick();

        // Random bursts: MDU stream order with random WB interference
        for (int b = 0; b < 10; b++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                r = 5'($urandom_range(0, 15));
                d = $urandom;
                mdu(r, d);
                done  = 1'b0;
                guard = 0;
                while (!done) begin
                    if ($urandom_range(0, 1) == 1) wb(5'($urandom_range(16, 31)), $urandom);
                    else bus.wb_valid = 1'b0;
                    accepted = bus.mdu_ready;
                    if (accepted && r != 5'd0) loq.push_back({r, d});
                    tick();
                    guard++;
                    if (accepted) done = 1'b1;
                    else if (guard > 50) begin
                        chk("offer_timeout", guard, 0);
                        done = 1'b1;
                    end
                end
            end
            idle();
            repeat ($urandom_range(0, 3)) tick();
        end
        idle();
        repeat (10) tick();
        chk("burst_lo_drained", loq.size(), 0);
        chk("burst_hi_drained", hiq.size(), 0);

        // Asynchronous reset with two entries queued
        wb(5'd20, 32'h500); mdu(5'd1, 32'h2001);
        tick();
        wb(5'd20, 32'h501); mdu(5'd2, 32'h2002);
        tick();
        idle();
        chk("pre_rst_mask", bus.pending_mask, 32'h6);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_regwrite", bus.regwrite, 1'b0);
        chk("async_rst_mask", bus.pending_mask, 32'h0);
        chk("async_rst_ready", bus.mdu_ready, 1'b1);
        tick(); tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("post_rst_mask", bus.pending_mask, 32'h0);
        chk("post_rst_hi_empty", hiq.size(), 0);
        chk("post_rst_lo_empty", loq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
